systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//  Transmit side of the PE row/col operand interface. Accepts one K-step beat per handshake:
//  N row operands and N col operands. Injects each lane into the west/north edge of the NxN
//  systolic array with lane i delayed i cycles (diagonal skew). Flushes with zeros after the
//  last beat, then signals that sums are final. Sits between the operand buffer and the array.
// PARAMETERS
//  N      4    array dimension (lanes per edge)
//  DW     16   lane width; matches PE west_row_in/north_col_in
//  CNTW   16   width of beat counter
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  s_valid        in   1       beat valid
//  s_ready        out  1       feeder can accept beat
//  s_row          in   N*DW    row operands, lane i = [i*DW +: DW]
//  s_col          in   N*DW    col operands, lane j = [j*DW +: DW]
//  s_last         in   1       final beat of tile (sampled on accept)
//  west_row_out   out  N*DW    to west_row_in of PE(i,0)
//  north_col_out  out  N*DW    to north_col_in of PE(0,j)
//  tile_start     out  1       1-cycle pulse: first beat of tile accepted (clear accumulators)
//  tile_done      out  1       1-cycle pulse: all PE sums final
//  beat_count     out  CNTW    beats accepted in current/last tile
// BEHAVIOUR
//  - Reset: state IDLE; every skew register, west_row_out, north_col_out = 0; s_ready=0;
//    tile_start=0; tile_done=0; beat_count=0. Reset mid-tile discards the tile; no tile_done.
//  - Accept = s_valid & s_ready. Stage 0 of every lane loads accepted data, or 0 when no accept.
//    Zero bubbles are harmless (0*x adds 0) and keep row/col alignment.
//  - Latency: beat accepted at cycle t -> lane i appears on both edge outputs at t+1+i.
//    Lane i uses i extra registers; lane 0 is registered once.
//  - FSM:
//    IDLE   s_ready=1. Accept -> tile_start=1, beat_count=1; s_last ? FLUSH : STREAM.
//    STREAM s_ready=1. Accept -> beat_count+1; accept with s_last -> FLUSH.
//           No s_valid -> stay in STREAM and inject zeros.
//    FLUSH  s_ready=0; zeros injected; counter runs 2N-1 cycles
//           (skew N-1 + propagation N-1 + accumulate 1) -> DONE.
//    DONE   s_ready=0; tile_done=1 for exactly one cycle -> IDLE.
//  - s_last on a tile's only beat is legal: IDLE -> FLUSH directly.
//  - beat_count saturates at 2^CNTW-1, no wrap. Held after tile_done; reloaded to 1 on next tile_start.
//  - tile_start and tile_done never coincide. Earliest tile_start after tile_done is the next cycle.
//  - Inputs sampled only on accept; s_row/s_col/s_last are don't-care otherwise.
// STRUCTURE
//  - Package systolic_pkg: localparams N, DW; typedef enum {IDLE,STREAM,FLUSH,DONE} feeder_state_t;
//    typedef logic [DW-1:0] lane_t.
//  - Sub-module skew_line #(DEPTH, DW): DEPTH-stage shift register, sync reset to 0.
//    Instantiated 2N times with DEPTH = i+1 via generate.
//  - FSM, flush counter and beat counter live in the top.
// TESTING (N=4, DW=16)
//  1 Single beat, s_last=1, row=col={4,3,2,1} at t0:
//    west lane i = i+1 at t0+1+i, otherwise 0; tile_start @t0; tile_done @t0+1+7; s_ready=0 in between.
//  2 Four back-to-back beats, beat k all lanes = k+1, last on k=3:
//    lane 2 shows 1,2,3,4 at t0+3..t0+6; beat_count=4; tile_done 7 cycles after FLUSH entry +1.
//  3 s_valid gap of 2 cycles mid-tile: zeros appear on lane 0 for 2 cycles and on lane 3 for
//    2 cycles 3 cycles later; beat_count excludes the gap.
//  4 s_valid held high during FLUSH/DONE: no accept, beat_count unchanged,
//    next tile's tile_start one cycle after tile_done.
//  5 rst asserted in STREAM with nonzero skew registers: next cycle all outputs 0, IDLE,
//    s_ready=1, no tile_done ever issued.
//  6 Scoreboard: 4x4 int operand tiles, K=8, random valid gaps.
//    Sums read from pe array at tile_done equal the reference matrix product.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the systolic operand feeder.
// Array size, lane width, feeder FSM states and lane data type.
package systolic_pkg;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int CNTW = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;

    typedef logic [DW-1:0] lane_t;

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage shift register used to skew one array edge lane.
// Ports: clk, rst (sync, active-high), d (stage 0 input), q (last stage).
module skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    import systolic_pkg::*;

    logic [DW-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                sr[k] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonally skewed operand injector for the west/north edges of an NxN array.
// Ports: clk, rst, s_valid/s_ready/s_row/s_col/s_last (beat in),
//        west_row_out, north_col_out (edges), tile_start, tile_done, beat_count.
module systolic_skew_feeder #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N*DW-1:0] s_row,
    input  logic [N*DW-1:0] s_col,
    input  logic            s_last,
    output logic [N*DW-1:0] west_row_out,
    output logic [N*DW-1:0] north_col_out,
    output logic            tile_start,
    output logic            tile_done,
    output logic [CNTW-1:0] beat_count
);
    import systolic_pkg::*;

    // Flush covers lane skew (N-1), propagation across the array (N-1)
    // and the final accumulate (1).
    localparam int FW = (2*N > 2) ? $clog2(2*N) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);

    feeder_state_t state;
    feeder_state_t state_nx;
    logic [FW-1:0] fcnt;
    logic          accept;

    assign s_ready    = ~rst & ((state == IDLE) | (state == STREAM));
    assign accept     = s_valid & s_ready;
    assign tile_start = accept & (state == IDLE);
    assign tile_done  = ~rst & (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = s_last ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (accept && s_last) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (fcnt == FLUSH_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fcnt       <= '0;
            beat_count <= '0;
        end else begin
            state <= state_nx;
            if (state == FLUSH) begin
                fcnt <= fcnt + 1'b1;
            end else begin
                fcnt <= '0;
            end
            if (tile_start) begin
                beat_count <= CNTW'(1);
            end else if (accept && (beat_count != '1)) begin
                beat_count <= beat_count + 1'b1;
            end
        end
    end

    // Non-accept cycles inject zeros so the row/col wavefronts stay aligned.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] row_d;
        logic [DW-1:0] col_d;

        assign row_d = accept ? s_row[i*DW +: DW] : '0;
        assign col_d = accept ? s_col[i*DW +: DW] : '0;

        skew_line #(.DEPTH(i+1), .DW(DW)) u_row (
            .clk (clk),
            .rst (rst),
            .d   (row_d),
            .q   (west_row_out[i*DW +: DW])
        );

        skew_line #(.DEPTH(i+1), .DW(DW)) u_col (
            .clk (clk),
            .rst (rst),
            .d   (col_d),
            .q   (north_col_out[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a downstream 4x4 PE array model.
// Checks skew timing, handshake, counters, reset and matrix-product results.
module tb_systolic_skew_feeder;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_row;
    logic [63:0] s_col;
    logic        s_last;
    logic [63:0] west_row_out;
    logic [63:0] north_col_out;
    logic        tile_start;
    logic        tile_done;
    logic [15:0] beat_count;

    int tests = 0;
    int fails = 0;

    logic        sv [64];
    logic        sl [64];
    logic [63:0] sr [64];
    logic [63:0] sc [64];
    logic [15:0] bcm;

    int unsigned ma [4][8];
    int unsigned mb [8][4];

    logic [15:0] wa   [4][4];
    logic [15:0] nb   [4][4];
    logic [15:0] pa   [4][4];
    logic [15:0] pb   [4][4];
    int unsigned pacc [4][4];

    systolic_skew_feeder #(.N(4), .DW(16), .CNTW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_row         (s_row),
        .s_col         (s_col),
        .s_last        (s_last),
        .west_row_out  (west_row_out),
        .north_col_out (north_col_out),
        .tile_start    (tile_start),
        .tile_done     (tile_done),
        .beat_count    (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                wa[i][j] = (j == 0) ? west_row_out[i*16 +: 16] : pa[i][(j == 0) ? 0 : j-1];
                nb[i][j] = (i == 0) ? north_col_out[j*16 +: 16] : pb[(i == 0) ? 0 : i-1][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pa[i][j] <= wa[i][j];
                pb[i][j] <= nb[i][j];
                pacc[i][j] <= tile_start ? 32'd0 :
                    pacc[i][j] + 32'(wa[i][j]) * 32'(nb[i][j]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 64; c++) begin
            sv[c] = 1'b0;
            sl[c] = 1'b0;
            sr[c] = '0;
            sc[c] = '0;
        end
    endtask

    task automatic beat(input int c, input logic last,
                        input logic [63:0] r, input logic [63:0] q);
        sv[c] = 1'b1;
        sl[c] = last;
        sr[c] = r;
        sc[c] = q;
    endtask

    // Plays sv/sl/sr/sc from IDLE until the expected tile_done cycle.
    task automatic run(input string name);
        logic [63:0] ir [64];
        logic [63:0] ic [64];
        int          last_c;
        logic        in_tile;
        logic        rdy;
        logic        acc;
        logic        fin;
        logic [15:0] ew;
        logic [15:0] en;
        last_c  = -1000;
        in_tile = 1'b0;
        fin     = 1'b0;
        for (int c = 0; c < 64 && !fin; c++) begin
            @(negedge clk);
            s_valid = sv[c];
            s_last  = sl[c];
            s_row   = sr[c];
            s_col   = sc[c];
            #1;
            rdy = (c > last_c + 8);
            acc = rdy & sv[c];
            chk({name, ":s_ready"}, 32'(s_ready), 32'(rdy));
            chk({name, ":tile_start"}, 32'(tile_start), 32'(acc & ~in_tile));
            chk({name, ":tile_done"}, 32'(tile_done), 32'(c == last_c + 8));
            chk({name, ":beat_count"}, 32'(beat_count), 32'(bcm));
            for (int i = 0; i < 4; i++) begin
                ew = (c - 1 - i >= 0) ? ir[c-1-i][i*16 +: 16] : 16'd0;
                en = (c - 1 - i >= 0) ? ic[c-1-i][i*16 +: 16] : 16'd0;
                chk($sformatf("%s:west%0d@%0d", name, i, c),
                    32'(west_row_out[i*16 +: 16]), 32'(ew));
                chk($sformatf("%s:north%0d@%0d", name, i, c),
                    32'(north_col_out[i*16 +: 16]), 32'(en));
            end
            ir[c] = acc ? sr[c] : '0;
            ic[c] = acc ? sc[c] : '0;
            if (c == last_c + 8) begin
                fin     = 1'b1;
                in_tile = 1'b0;
            end
            if (acc) begin
                bcm = in_tile ? ((bcm == 16'hFFFF) ? bcm : bcm + 16'd1) : 16'd1;
                in_tile = 1'b1;
                if (sl[c]) begin
                    last_c = c;
                end
            end
        end
        chk({name, ":finished"}, 32'(fin), 32'd1);
    endtask

    task automatic mm_tile(input string name);
        int c;
        int unsigned ref_sum;
        logic [63:0] r;
        logic [63:0] q;
        clr();
        c = 0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                ma[i][k] = $urandom_range(0, 255);
                mb[k][i] = $urandom_range(0, 255);
                r[i*16 +: 16] = 16'(ma[i][k]);
                q[i*16 +: 16] = 16'(mb[k][i]);
            end
            beat(c, k == 7, r, q);
            c = c + 1 + int'($urandom_range(0, 2));
        end
        run(name);
        chk({name, ":beats"}, 32'(beat_count), 32'd8);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ref_sum = 0;
                for (int k = 0; k < 8; k++) begin
                    ref_sum += ma[i][k] * mb[k][j];
                end
                chk($sformatf("%s:C[%0d][%0d]", name, i, j), pacc[i][j], ref_sum);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_row   = '0;
        s_col   = '0;
        bcm     = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst:s_ready", 32'(s_ready), 32'd0);
        chk("rst:west", west_row_out[31:0], 32'd0);
        chk("rst:north", north_col_out[63:32], 32'd0);
        chk("rst:tile_start", 32'(tile_start), 32'd0);
        chk("rst:tile_done", 32'(tile_done), 32'd0);
        chk("rst:beat_count", 32'(beat_count), 32'd0);
        rst = 1'b0;

        // 1: single beat with s_last
        clr();
        beat(0, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd4, 16'd3, 16'd2, 16'd1});
        run("t1");
        chk("t1:count", 32'(beat_count), 32'd1);

        // 2: four back-to-back beats
        clr();
        for (int k = 0; k < 4; k++) begin
            beat(k, k == 3, {4{16'(k+1)}}, {4{16'(k+1)}});
        end
        run("t2");
        chk("t2:count", 32'(beat_count), 32'd4);

        // 3: two-cycle valid gap mid-tile
        clr();
        beat(0, 1'b0, {16'h13, 16'h12, 16'h11, 16'h10}, {16'h23, 16'h22, 16'h21, 16'h20});
        beat(1, 1'b0, {16'h33, 16'h32, 16'h31, 16'h30}, {16'h43, 16'h42, 16'h41, 16'h40});
        beat(4, 1'b0, {16'h53, 16'h52, 16'h51, 16'h50}, {16'h63, 16'h62, 16'h61, 16'h60});
        beat(5, 1'b1, {16'h73, 16'h72, 16'h71, 16'h70}, {16'h83, 16'h82, 16'h81, 16'h80});
        run("t3");
        chk("t3:count", 32'(beat_count), 32'd4);

        // 4: s_valid held through FLUSH/DONE, next tile right after done
        clr();
        beat(0, 1'b1, {4{16'h00AA}}, {4{16'h00BB}});
        for (int c = 1; c < 9; c++) begin
            beat(c, 1'b1, {4{16'hFFFF}}, {4{16'hEEEE}});
        end
        run("t4a");
        chk("t4a:count", 32'(beat_count), 32'd1);
        clr();
        beat(0, 1'b0, {4{16'h0055}}, {4{16'h0066}});
        beat(1, 1'b1, {4{16'h0077}}, {4{16'h0088}});
        run("t4b");
        chk("t4b:count", 32'(beat_count), 32'd2);

        // 5: reset while streaming
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_last  = 1'b0;
            s_row   = {4{16'(c+5)}};
            s_col   = {4{16'(c+9)}};
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("t5:pre_west0", 32'(west_row_out[15:0]), 32'd7);
        chk("t5:rst_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bcm = 16'd0;
        #1;
        chk("t5:west", west_row_out[63:32], 32'd0);
        chk("t5:west_lo", west_row_out[31:0], 32'd0);
        chk("t5:north", north_col_out[63:32], 32'd0);
        chk("t5:north_lo", north_col_out[31:0], 32'd0);
        chk("t5:s_ready", 32'(s_ready), 32'd1);
        chk("t5:beat_count", 32'(beat_count), 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t5:no_done@%0d", c), 32'(tile_done), 32'd0);
        end

        // 6: matrix products with random gaps
        mm_tile("t6a");
        mm_tile("t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
